// File: rtl/sparse_entry_fetch.sv
// Sparse matrix entry capture stage: edge-detects the CPU strobe, drops zero
// values (except end-of-list markers), buffers entries in a show-ahead FIFO
// and hands them to the accelerator core over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | block disabled or between lists; nothing captured
// LOAD  | accepting CPU strobes while FIFO has room
// DRAIN | final entry captured; waiting for it to be popped by the core
// DONE  | list fully delivered; held until ena drops
module sparse_entry_fetch #(
  parameter int DEPTH = 4,
  parameter int VAL_W = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [VAL_W-1:0] value_in,
  input  logic [IDX_W-1:0] row_in,
  input  logic [IDX_W-1:0] col_in,
  input  logic             sending_CPU,
  input  logic             done_list,
  output logic             FETCH_ready,
  output logic             ent_valid,
  input  logic             ent_ready,
  output logic [VAL_W-1:0] ent_value,
  output logic [IDX_W-1:0] ent_row,
  output logic [IDX_W-1:0] ent_col,
  output logic             ent_last,
  output logic             list_done,
  output logic [4:0]       nz_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = VAL_W + 2 * IDX_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic            sending_q;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            strobe, accept, push, pop, head_last, val_nz;
  logic [EW-1:0]   head;

  assign strobe      = sending_CPU & ~sending_q;
  // Ready depends only on registered state so the CPU never sees a
  // combinational path from the core's ent_ready.
  assign FETCH_ready = (state == LOAD) && (count < CW'(DEPTH));
  assign accept      = strobe && FETCH_ready;
  assign val_nz      = (value_in != '0);
  // A zero value still travels when it closes the list, so the core sees last.
  assign push        = accept && (val_nz || done_list);
  assign ent_valid   = (count != '0);
  assign pop         = ent_valid && ent_ready;
  assign head        = mem[rd_ptr];
  assign head_last   = head[0];
  assign {ent_value, ent_row, ent_col, ent_last} = ent_valid ? head : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; dropping ena always returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ena) state_nx = LOAD;
      LOAD:    if (accept && done_list) state_nx = DRAIN;
      DRAIN:   if (pop && head_last) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (!ena) state_nx = IDLE;
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {value_in, row_in, col_in, done_list};
  end

  // FIFO pointers and occupancy; ena low discards everything buffered.
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Strobe history, per-list statistics and end-of-list pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sending_q <= 1'b0;
      nz_count  <= '0;
      overflow  <= 1'b0;
      list_done <= 1'b0;
    end else begin
      sending_q <= sending_CPU;
      if (!ena) begin
        nz_count  <= '0;
        overflow  <= 1'b0;
        list_done <= 1'b0;
      end else begin
        list_done <= pop && head_last;
        if (strobe && !FETCH_ready) overflow <= 1'b1;
        if (push && val_nz && (nz_count != 5'd31)) nz_count <= nz_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sparse_entry_fetch.sv
// Scenario bench for sparse_entry_fetch: expected entries are queued as the
// CPU side is driven and compared when the core side pops them.
module tb_sparse_entry_fetch;

  logic       clk = 1'b0;
  logic       rst_n, ena, sending_CPU, done_list, ent_ready;
  logic [7:0] value_in;
  logic [1:0] row_in, col_in;
  logic       FETCH_ready, ent_valid, ent_last, list_done, overflow;
  logic [7:0] ent_value;
  logic [1:0] ent_row, ent_col;
  logic [4:0] nz_count;

  int tests_run = 0;
  int failed    = 0;
  int pops      = 0;
  int ld_cnt    = 0;
  logic [12:0] sb [$];

  sparse_entry_fetch #(.DEPTH(4), .VAL_W(8), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .value_in(value_in), .row_in(row_in), .col_in(col_in),
    .sending_CPU(sending_CPU), .done_list(done_list),
    .FETCH_ready(FETCH_ready), .ent_valid(ent_valid), .ent_ready(ent_ready),
    .ent_value(ent_value), .ent_row(ent_row), .ent_col(ent_col),
    .ent_last(ent_last), .list_done(list_done), .nz_count(nz_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Core-side scoreboard: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    logic [12:0] exp_e;
    if (list_done) ld_cnt++;
    if (rst_n && ent_valid && ent_ready) begin
      pops++;
      tests_run++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL pop_unexpected got %h/%0d/%0d/%b, none expected",
                 ent_value, ent_row, ent_col, ent_last);
      end else begin
        exp_e = sb.pop_front();
        if ({ent_value, ent_row, ent_col, ent_last} !== exp_e) begin
          failed++;
          $display("FAIL pop_entry got %h/%0d/%0d/%b expected %h/%0d/%0d/%b",
                   ent_value, ent_row, ent_col, ent_last,
                   exp_e[12:5], exp_e[4:3], exp_e[2:1], exp_e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU transfer: strobe high for a cycle, then low for a cycle.
  task automatic send(input logic [7:0] v, input logic [1:0] r, input logic [1:0] c,
                      input logic d, input logic acc);
    value_in = v; row_in = r; col_in = c; done_list = d; sending_CPU = 1'b1;
    if (acc && (v != 8'd0 || d)) sb.push_back({v, r, c, d});
    tick();
    sending_CPU = 1'b0;
    tick();
  endtask

  task automatic restart();
    ena = 1'b0;
    tick();
    ena = 1'b1;
    tick();
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; sending_CPU = 1'b0; done_list = 1'b0;
    ent_ready = 1'b0; value_in = '0; row_in = '0; col_in = '0;
    tick(); tick();
    tests_run++;
    if ({FETCH_ready, ent_valid, ent_value, ent_last, list_done, nz_count, overflow} !== '0) begin
      failed++;
      $display("FAIL reset_outputs rdy=%b vld=%b val=%h nz=%0d ovf=%b expected all 0",
               FETCH_ready, ent_valid, ent_value, nz_count, overflow);
    end
    rst_n = 1'b1; ena = 1'b1;
    tick();
    tests_run++;
    if (FETCH_ready !== 1'b1) begin
      failed++;
      $display("FAIL load_ready got %b expected 1", FETCH_ready);
    end
  endtask

  task automatic test_basic_list();
    int p0, l0;
    p0 = pops; l0 = ld_cnt;
    ent_ready = 1'b1;
    send(8'd5, 2'd1, 2'd2, 1'b0, 1'b1);
    send(8'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    send(8'd9, 2'd3, 2'd3, 1'b1, 1'b1);
    repeat (4) tick();
    tests_run++;
    if (pops - p0 !== 2) begin failed++; $display("FAIL basic_pops got %0d expected 2", pops - p0); end
    tests_run++;
    if (nz_count !== 5'd2) begin failed++; $display("FAIL basic_nz got %0d expected 2", nz_count); end
    tests_run++;
    if (ld_cnt - l0 !== 1) begin failed++; $display("FAIL basic_list_done got %0d expected 1", ld_cnt - l0); end
    tests_run++;
    if (FETCH_ready !== 1'b0) begin failed++; $display("FAIL basic_done_ready got %b expected 0", FETCH_ready); end
    restart();
  endtask

  task automatic test_overflow();
    ent_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 2'(i), 2'(3 - i), 1'b0, 1'b1);
    tests_run++;
    if (FETCH_ready !== 1'b0) begin failed++; $display("FAIL full_ready got %b expected 0", FETCH_ready); end
    send(8'h77, 2'd0, 2'd0, 1'b0, 1'b0);
    tests_run++;
    if (overflow !== 1'b1) begin failed++; $display("FAIL overflow_set got %b expected 1", overflow); end
    ent_ready = 1'b1;
    repeat (6) tick();
    ent_ready = 1'b0;
    tests_run++;
    if (sb.size() !== 0 || ent_valid !== 1'b0 || ent_value !== 8'd0) begin
      failed++;
      $display("FAIL overflow_drain left=%0d vld=%b val=%h expected 0/0/0", sb.size(), ent_valid, ent_value);
    end
    tests_run++;
    if (overflow !== 1'b1 || FETCH_ready !== 1'b1) begin
      failed++;
      $display("FAIL overflow_sticky ovf=%b rdy=%b expected 1/1", overflow, FETCH_ready);
    end
    restart();
  endtask

  task automatic test_full_push_pop();
    int p0;
    p0 = pops;
    ent_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 2'(i), 2'(i), 1'b0, 1'b1);
    value_in = 8'h07; row_in = 2'd1; col_in = 2'd1; done_list = 1'b0;
    sending_CPU = 1'b1; ent_ready = 1'b1;
    tick();
    sending_CPU = 1'b0; ent_ready = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || FETCH_ready !== 1'b1) begin
      failed++;
      $display("FAIL full_pushpop ovf=%b rdy=%b expected 1/1 (count 3)", overflow, FETCH_ready);
    end
    ent_ready = 1'b1;
    repeat (5) tick();
    ent_ready = 1'b0;
    tests_run++;
    if (pops - p0 !== 4 || sb.size() !== 0) begin
      failed++;
      $display("FAIL full_pushpop_pops got %0d left %0d expected 4/0", pops - p0, sb.size());
    end
    restart();
  endtask

  task automatic test_zero_done();
    int l0;
    l0 = ld_cnt;
    ent_ready = 1'b1;
    send(8'd0, 2'd2, 2'd1, 1'b1, 1'b1);
    repeat (3) tick();
    tests_run++;
    if (nz_count !== 5'd0 || ld_cnt - l0 !== 1 || sb.size() !== 0) begin
      failed++;
      $display("FAIL zero_done nz=%0d ld=%0d left=%0d expected 0/1/0", nz_count, ld_cnt - l0, sb.size());
    end
    ent_ready = 1'b0;
    send(8'd4, 2'd0, 2'd0, 1'b0, 1'b0);
    tests_run++;
    if (ent_valid !== 1'b0 || FETCH_ready !== 1'b0) begin
      failed++;
      $display("FAIL done_state vld=%b rdy=%b expected 0/0", ent_valid, FETCH_ready);
    end
    restart();
  endtask

  task automatic test_held_strobe();
    ent_ready = 1'b0;
    value_in = 8'd3; row_in = 2'd2; col_in = 2'd0; done_list = 1'b0;
    sending_CPU = 1'b1;
    sb.push_back({8'd3, 2'd2, 2'd0, 1'b0});
    repeat (10) tick();
    sending_CPU = 1'b0;
    tick();
    tests_run++;
    if (ent_valid !== 1'b1 || nz_count !== 5'd1) begin
      failed++;
      $display("FAIL held_capture vld=%b nz=%0d expected 1/1", ent_valid, nz_count);
    end
    ent_ready = 1'b1;
    tick();
    ent_ready = 1'b0;
    tick();
    tests_run++;
    if (ent_valid !== 1'b0) begin failed++; $display("FAIL held_single vld=%b expected 0", ent_valid); end
    restart();
  endtask

  task automatic test_saturate();
    ent_ready = 1'b1;
    for (int i = 0; i < 33; i++) send(8'(i + 1), 2'(i), 2'(i >> 2), 1'b0, 1'b1);
    tick();
    ent_ready = 1'b0;
    tests_run++;
    if (nz_count !== 5'd31 || sb.size() !== 0) begin
      failed++;
      $display("FAIL nz_saturate nz=%0d left=%0d expected 31/0", nz_count, sb.size());
    end
    restart();
  endtask

  task automatic test_flush();
    int l0;
    l0 = ld_cnt;
    ent_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 2'(i), 2'(i), 1'b0, 1'b1);
    tests_run++;
    if (ent_valid !== 1'b1 || nz_count !== 5'd3) begin
      failed++;
      $display("FAIL flush_pre vld=%b nz=%0d expected 1/3", ent_valid, nz_count);
    end
    ena = 1'b0;
    tick();
    sb.delete();
    tests_run++;
    if (ent_valid !== 1'b0 || nz_count !== 5'd0 || overflow !== 1'b0 || FETCH_ready !== 1'b0) begin
      failed++;
      $display("FAIL flush_ena vld=%b nz=%0d ovf=%b rdy=%b expected 0/0/0/0",
               ent_valid, nz_count, overflow, FETCH_ready);
    end
    ena = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i), 2'(i), 2'(i), 1'b0, 1'b1);
    send(8'h55, 2'd0, 2'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    sb.delete();
    tests_run++;
    if (ent_valid !== 1'b0 || nz_count !== 5'd0 || overflow !== 1'b0 || FETCH_ready !== 1'b0) begin
      failed++;
      $display("FAIL flush_rst vld=%b nz=%0d ovf=%b rdy=%b expected 0/0/0/0",
               ent_valid, nz_count, overflow, FETCH_ready);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (ld_cnt - l0 !== 0 || ent_valid !== 1'b0 || FETCH_ready !== 1'b1) begin
      failed++;
      $display("FAIL flush_after ld=%0d vld=%b rdy=%b expected 0/0/1", ld_cnt - l0, ent_valid, FETCH_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_list();
    test_overflow();
    test_full_push_pop();
    test_zero_done();
    test_held_strobe();
    test_saturate();
    test_flush();
    tests_run++;
    if (sb.size() !== 0) begin failed++; $display("FAIL scoreboard_left got %0d expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
